// File: rtl/palette_pkg.sv
// Shared types and constants for the sprite palette lookup.
//   rgb_t      : packed colour, {r, g, b}, one CH_W-bit byte per channel
//   pal_mode_t : colour effect applied on the lookup path
//   CH_W       : width of one colour channel
package palette_pkg;

    localparam int CH_W = 8;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PM_NORMAL = 2'b00,
        PM_HALF   = 2'b01,
        PM_INVERT = 2'b10,
        PM_GRAY   = 2'b11
    } pal_mode_t;

endpackage

// File: rtl/palette_color_fx.sv
// Combinational colour effect unit.
//   i_color : packed colour {R, G, B}, COLOR_W/3 bits per channel
//   i_mode  : effect select (normal, half, invert, gray)
//   o_color : colour with the effect applied
module palette_color_fx
    import palette_pkg::*;
#(
    parameter int COLOR_W = 24
) (
    input  logic [COLOR_W-1:0] i_color,
    input  pal_mode_t          i_mode,
    output logic [COLOR_W-1:0] o_color
);

    localparam int CW = COLOR_W / 3;

    function automatic logic [CW-1:0] half_ch(input logic [CW-1:0] c);
        return c >> 1;
    endfunction

    // All-ones minus c is a plain bitwise complement.
    function automatic logic [CW-1:0] invert_ch(input logic [CW-1:0] c);
        return ~c;
    endfunction

    // Luma approximation (R + 2G + B) / 4. The sum needs two extra bits;
    // dropping the low two bits of it leaves exactly CW bits.
    function automatic logic [CW-1:0] gray_y(input logic [CW-1:0] r,
                                              input logic [CW-1:0] g,
                                              input logic [CW-1:0] b);
        logic [CW+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[CW+1:2];
    endfunction

    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic [CW-1:0] y;

    assign r = i_color[3*CW-1:2*CW];
    assign g = i_color[2*CW-1:CW];
    assign b = i_color[CW-1:0];
    assign y = gray_y(r, g, b);

    always_comb begin
        o_color = i_color;
        case (i_mode)
            PM_NORMAL: o_color = i_color;
            PM_HALF:   o_color = {half_ch(r), half_ch(g), half_ch(b)};
            PM_INVERT: o_color = {invert_ch(r), invert_ch(g), invert_ch(b)};
            PM_GRAY:   o_color = {y, y, y};
            default:   o_color = i_color;
        endcase
    end

endmodule

// File: rtl/sprite_palette_lut.sv
// Runtime-loadable multi-bank palette lookup for indexed sprite pixels.
// A pixel index presented with i_px_valid returns the colour of the active
// bank, with the active effect applied, two cycles later. Bank and effect
// requests are shadowed and only committed on i_frame_start.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_frame_start           : commits i_bank_sel / i_mode
//   i_bank_sel, i_mode      : requested bank and effect
//   i_px_valid, i_px_idx    : lookup request
//   i_wr_en, i_wr_bank,
//   i_wr_idx, i_wr_color    : palette entry write port
//   o_color, o_transparent,
//   o_valid                 : lookup response (2-cycle latency)
//   o_active_bank           : currently committed bank
module sprite_palette_lut
    import palette_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int NUM_BANKS  = 4,
    parameter int COLOR_W    = 24,
    parameter int TRANSP_IDX = 0,
    parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_start,
    input  logic [BANK_W-1:0]  i_bank_sel,
    input  logic [1:0]         i_mode,
    input  logic               i_px_valid,
    input  logic [IDX_W-1:0]   i_px_idx,
    input  logic               i_wr_en,
    input  logic [BANK_W-1:0]  i_wr_bank,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [COLOR_W-1:0] i_wr_color,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_transparent,
    output logic               o_valid,
    output logic [BANK_W-1:0]  o_active_bank
);

    localparam int                DEPTH     = 2 ** IDX_W;
    localparam logic [BANK_W:0]   NB        = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [IDX_W-1:0]  TRANSP_IX = IDX_W'(TRANSP_IDX);

    // Bank numbers past the last palette exist only for non-power-of-2
    // bank counts; they are never committed and never written.
    function automatic logic bank_ok(input logic [BANK_W-1:0] bank);
        return {1'b0, bank} < NB;
    endfunction

    logic [COLOR_W-1:0] mem [NUM_BANKS][DEPTH];

    logic [BANK_W-1:0]  active_bank;
    pal_mode_t          active_mode;

    logic               vld_p1;
    logic [COLOR_W-1:0] color_p1;
    logic               transp_p1;
    logic [COLOR_W-1:0] fx_color;

    // Write port: the read in S1 samples the array before this edge's
    // update, so a colliding lookup sees the old entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int bk = 0; bk < NUM_BANKS; bk++) begin
                for (int ix = 0; ix < DEPTH; ix++) begin
                    mem[bk][ix] <= '0;
                end
            end
        end else if (i_wr_en && bank_ok(i_wr_bank)) begin
            mem[i_wr_bank][i_wr_idx] <= i_wr_color;
        end
    end

    // Frame commit: a lookup sampled on the commit edge still reads the
    // previous bank because S1 uses the registered value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_bank <= '0;
            active_mode <= PM_NORMAL;
        end else if (i_frame_start) begin
            if (bank_ok(i_bank_sel)) begin
                active_bank <= i_bank_sel;
            end
            active_mode <= pal_mode_t'(i_mode);
        end
    end

    assign o_active_bank = active_bank;

    // ---- Stage 1: latch request and raw palette entry ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1    <= 1'b0;
            color_p1  <= '0;
            transp_p1 <= 1'b0;
        end else begin
            vld_p1 <= i_px_valid;
            if (i_px_valid) begin
                color_p1  <= mem[active_bank][i_px_idx];
                transp_p1 <= (i_px_idx == TRANSP_IX);
            end
        end
    end

    // The effect uses the mode in force while the request sits in S1.
    palette_color_fx #(
        .COLOR_W (COLOR_W)
    ) u_fx (
        .i_color (color_p1),
        .i_mode  (active_mode),
        .o_color (fx_color)
    );

    // ---- Stage 2: registered response, zeroed when idle or transparent ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_transparent <= 1'b0;
            o_color       <= '0;
        end else begin
            o_valid       <= vld_p1;
            o_transparent <= vld_p1 & transp_p1;
            o_color       <= (vld_p1 && !transp_p1) ? fx_color : '0;
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
module tb_sprite_palette_lut;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [1:0]  bank_sel;
    logic [1:0]  mode;
    logic        px_valid;
    logic [3:0]  px_idx;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_idx;
    logic [23:0] wr_color;
    logic [23:0] o_color;
    logic        o_transparent;
    logic        o_valid;
    logic [1:0]  o_active_bank;

    sprite_palette_lut dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_bank_sel    (bank_sel),
        .i_mode        (mode),
        .i_px_valid    (px_valid),
        .i_px_idx      (px_idx),
        .i_wr_en       (wr_en),
        .i_wr_bank     (wr_bank),
        .i_wr_idx      (wr_idx),
        .i_wr_color    (wr_color),
        .o_color       (o_color),
        .o_transparent (o_transparent),
        .o_valid       (o_valid),
        .o_active_bank (o_active_bank)
    );

    typedef struct {
        logic [23:0] color;
        logic        transp;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: pops one expectation per valid response, checks latency too.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_valid: got o_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency_cycle", 32'(cyc), 32'(e.due));
                    chk("color", 32'(o_color), 32'(e.color));
                    chk("transparent", 32'(o_transparent), 32'(e.transp));
                end
            end else begin
                chk("idle_zero", {7'd0, o_transparent, o_color}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        px_valid    = 1'b0;
        wr_en       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic issue(input logic [3:0] idx, input logic [23:0] c, input logic t);
        exp_t e;
        px_valid = 1'b1;
        px_idx   = idx;
        e.color  = c;
        e.transp = t;
        e.due    = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic write(input logic [1:0] bk, input logic [3:0] idx, input logic [23:0] c);
        wr_en    = 1'b1;
        wr_bank  = bk;
        wr_idx   = idx;
        wr_color = c;
    endtask

    task automatic commit(input logic [1:0] bk, input logic [1:0] md);
        frame_start = 1'b1;
        bank_sel    = bk;
        mode        = md;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    logic [23:0] b2b_tbl [8];

    initial begin
        b2b_tbl[0] = 24'h112233; b2b_tbl[1] = 24'h445566;
        b2b_tbl[2] = 24'h778899; b2b_tbl[3] = 24'haabbcc;
        b2b_tbl[4] = 24'hddeeff; b2b_tbl[5] = 24'h010203;
        b2b_tbl[6] = 24'hfedcba; b2b_tbl[7] = 24'h13579b;

        rst_n = 1'b0; frame_start = 1'b0; bank_sel = '0; mode = '0;
        px_valid = 1'b0; px_idx = '0; wr_en = 1'b0; wr_bank = '0;
        wr_idx = '0; wr_color = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_color", 32'(o_color), 32'd0);
        chk("rst_transp", 32'(o_transparent), 32'd0);
        chk("rst_bank", 32'(o_active_bank), 32'd0);

        // 1: cleared entries; index 0 is transparent
        issue(4'd3, 24'h000000, 1'b0); tick();
        issue(4'd0, 24'h000000, 1'b1); tick();
        drain();

        // 2: write then look up on the next cycle
        write(2'd0, 4'd5, 24'h8dfe8d); tick();
        issue(4'd5, 24'h8dfe8d, 1'b0); tick();
        drain();

        // 3: bank_sel alone has no effect; the commit edge still reads bank 0
        write(2'd2, 4'd5, 24'h00ffff); bank_sel = 2'd2; tick();
        issue(4'd5, 24'h8dfe8d, 1'b0); tick();
        drain();
        chk("bank_before_commit", 32'(o_active_bank), 32'd0);
        commit(2'd2, 2'b00);
        issue(4'd5, 24'h8dfe8d, 1'b0); tick();
        issue(4'd5, 24'h00ffff, 1'b0); tick();
        drain();
        chk("bank_after_commit", 32'(o_active_bank), 32'd2);

        // 4: effects on 24'h77dbbd
        write(2'd2, 4'd7, 24'h77dbbd); tick();
        issue(4'd7, 24'h77dbbd, 1'b0); tick();
        drain();
        commit(2'd2, 2'b01); tick();
        issue(4'd7, 24'h3b6d5e, 1'b0); tick();
        drain();
        commit(2'd2, 2'b10); tick();
        issue(4'd7, 24'h882442, 1'b0); tick();
        drain();
        // gray: 0x77 + 2*0xdb + 0xbd = 746, 746 >> 2 = 186 = 0xba
        commit(2'd2, 2'b11); tick();
        issue(4'd7, 24'hbababa, 1'b0); tick();
        drain();
        commit(2'd2, 2'b00); tick();

        // Transparent index overrides a non-zero stored entry
        write(2'd2, 4'd0, 24'hffffff); tick();
        issue(4'd0, 24'h000000, 1'b1); tick();
        drain();

        // 5: write/read collision returns the old colour, then the new one
        write(2'd2, 4'd9, 24'h123456);
        issue(4'd9, 24'h000000, 1'b0); tick();
        issue(4'd9, 24'h123456, 1'b0); tick();
        drain();

        // 8 back-to-back lookups
        for (int i = 0; i < 8; i++) begin
            write(2'd2, 4'(8 + i), b2b_tbl[i]);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            issue(4'(8 + i), b2b_tbl[i], 1'b0);
            tick();
        end
        drain();

        // 6: reset with two lookups in flight
        issue(4'd7, 24'h77dbbd, 1'b0); tick();
        issue(4'd5, 24'h00ffff, 1'b0); tick();
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_color", 32'(o_color), 32'd0);
        chk("midrst_bank", 32'(o_active_bank), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(4'd5, 24'h000000, 1'b0); tick();
        drain();
        commit(2'd2, 2'b00); tick();
        issue(4'd7, 24'h000000, 1'b0); tick();
        drain();
        chk("post_rst_bank", 32'(o_active_bank), 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
